serial_port_router: RTL and testbench

Parametrised serial packet router: deframes a single-bit serial stream (start bit, port header, length header, payload, optional parity) and steers each payload bit to one of `NUM_PORTS` output lanes with a per-lane valid strobe. It is the next generation of the lab's fixed 4-port, 4-bit-length router. It adds generic port count, length width, optional parity, out-of-range port detection and a completion/status interface for the seven-segment display path.

---
 rtl/serial_port_router.sv | 98 +++++++++
 tb/tb_serial_port_router.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_port_router.sv
// serial_port_router: deframes a serial packet stream and steers payload bits to one of NUM_PORTS lanes.
module serial_port_router #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W = 2,
  parameter int LEN_W = 4,
  parameter int PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 serin,
  output logic [NUM_PORTS-1:0] data_out,
  output logic [NUM_PORTS-1:0] valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_port,
  output logic                 err_par,
  output logic [PORT_W-1:0]    cur_port,
  output logic [LEN_W-1:0]     cur_len,
  output logic [LEN_W-1:0]     rem
);
  localparam int CW = PORT_W > LEN_W ? PORT_W : LEN_W;
  typedef enum logic [2:0] {IDLE, PORT, LEN, DATA, PAR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PORT_W-1:0] port_sr;
  logic [LEN_W-1:0] len_sr, len_nx;
  logic [NUM_PORTS-1:0] sel;
  logic par, in_rng, hdr_last, fin;
  always_comb begin
    len_nx = LEN_W'({len_sr, serin});
    in_rng = {1'b0, port_sr} < (PORT_W+1)'(NUM_PORTS);
    sel = NUM_PORTS'(1) << port_sr;
    hdr_last = cnt == CW'(state == PORT ? PORT_W - 1 : LEN_W - 1);
    state_n = state;
    case (state)
      IDLE: state_n = serin ? IDLE : PORT;
      PORT: state_n = hdr_last ? LEN : PORT;
      LEN:  state_n = !hdr_last ? LEN : len_nx != '0 ? DATA : PARITY_EN != 0 ? PAR : IDLE;
      DATA: state_n = rem != LEN_W'(1) ? DATA : PARITY_EN != 0 ? PAR : IDLE;
      PAR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    fin = state != IDLE && state_n == IDLE;
  end
  // strobes clear every clk so they stay one clk wide whatever the clk_en rate
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      port_sr <= '0;
      len_sr <= '0;
      par <= 1'b0;
      data_out <= '0;
      valid <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_port <= 1'b0;
      err_par <= 1'b0;
      cur_port <= '0;
      cur_len <= '0;
      rem <= '0;
    end else begin
      valid <= '0;
      data_out <= '0;
      done <= 1'b0;
      err_port <= 1'b0;
      err_par <= 1'b0;
      if (clk_en) begin
        state <= state_n;
        cnt <= (state == PORT || state == LEN) && state_n == state ? cnt + 1'b1 : '0;
        if (state == IDLE) begin
          busy <= !serin;
          par <= 1'b0;
        end
        if (state == PORT) port_sr <= PORT_W'({port_sr, serin});
        if (state == LEN) len_sr <= len_nx;
        if (state == LEN && hdr_last) begin
          cur_port <= port_sr;
          cur_len <= len_nx;
          rem <= len_nx;
        end
        if (state == DATA) begin
          rem <= rem - 1'b1;
          par <= par ^ serin;
          valid <= sel;
          data_out <= serin ? sel : '0;
        end
        if (fin) begin
          busy <= 1'b0;
          done <= 1'b1;
          err_port <= !in_rng;
          err_par <= PARITY_EN != 0 && state == PAR && (par ^ serin);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_port_router.sv
// tb_serial_port_router: directed checks on default, 3-port and parity-enabled routers sharing one stream.
module tb_serial_port_router;
  logic clk = 1'b0;
  logic rst, clk_en, serin;
  logic [3:0] d0, v0, d2, v2;
  logic [2:0] d1, v1;
  logic b0, dn0, ep0, epar0, b1, dn1, ep1, epar1, b2, dn2, ep2, epar2;
  logic [1:0] cp0, cp1, cp2;
  logic [3:0] cl0, cl1, cl2, rm0, rm1, rm2;
  int pass = 0, total = 0;
  int vcnt = 0, bcnt = 0, dcnt = 0;
  int vc, bc, dc;

  always #5 clk = ~clk;

  serial_port_router u0 (.clk(clk), .rst(rst), .clk_en(clk_en), .serin(serin), .data_out(d0), .valid(v0),
    .busy(b0), .done(dn0), .err_port(ep0), .err_par(epar0), .cur_port(cp0), .cur_len(cl0), .rem(rm0));
  serial_port_router #(.NUM_PORTS(3)) u1 (.clk(clk), .rst(rst), .clk_en(clk_en), .serin(serin), .data_out(d1),
    .valid(v1), .busy(b1), .done(dn1), .err_port(ep1), .err_par(epar1), .cur_port(cp1), .cur_len(cl1), .rem(rm1));
  serial_port_router #(.PARITY_EN(1)) u2 (.clk(clk), .rst(rst), .clk_en(clk_en), .serin(serin), .data_out(d2),
    .valid(v2), .busy(b2), .done(dn2), .err_port(ep2), .err_par(epar2), .cur_port(cp2), .cur_len(cl2), .rem(rm2));

  always @(negedge clk) begin
    if (|v0) vcnt++;
    if (b0) bcnt++;
    if (dn0) dcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input logic b);
    @(negedge clk);
    rst = 1'b0;
    serin = b;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0;
      clk_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(bits[i]);
  endtask

  task automatic do_rst;
    @(negedge clk);
    rst = 1'b1;
    serin = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    serin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {v0, d0, b0, dn0, ep0, epar0, cp0, cl0, rm0}, 0);
    // basic: port 2, len 3, data 1,0,1
    bc = bcnt;
    vc = vcnt;
    send(7'b0100011, 7);
    chk("basic_hdr", {cp0, cl0, rm0, b0}, {2'd2, 4'd3, 4'd3, 1'b1});
    tick(1);
    chk("basic_d0", {v0, d0, rm0}, {4'b0100, 4'b0100, 4'd2});
    tick(0);
    chk("basic_d1", {v0, d0, dn0}, {4'b0100, 4'b0000, 1'b0});
    tick(1);
    chk("basic_done", {v0, d0, dn0, ep0, epar0, b0}, {4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0});
    tick(1);
    chk("basic_after", {v0, dn0}, 0);
    chk("basic_busy9", bcnt - bc, 9);
    chk("basic_valid3", vcnt - vc, 3);
    // zero length, port 1
    do_rst;
    vc = vcnt;
    send(7'b0010000, 7);
    chk("zero_done", {dn0, ep0, v0, cp0, cl0, b0}, {1'b1, 1'b0, 4'b0, 2'd1, 4'd0, 1'b0});
    tick(1);
    chk("zero_novalid", vcnt - vc, 0);
    // port 3 on a 3-port router
    do_rst;
    send(7'b0110010, 7);
    tick(1);
    chk("oor_d0", {v1, rm1, dn1}, {3'b000, 4'd1, 1'b0});
    chk("oor_u0_lane3", v0, 4'b1000);
    tick(1);
    chk("oor_done", {v1, dn1, ep1}, {3'b000, 1'b1, 1'b1});
    chk("oor_u0_ok", {dn0, ep0}, 2'b10);
    // parity: port 0, len 2, data 1,1
    do_rst;
    send(9'b000001011, 9);
    chk("par_data", {v2, dn2, b2, dn0}, {4'b0001, 1'b0, 1'b1, 1'b1});
    tick(0);
    chk("par_ok", {dn2, epar2, ep2, b2}, 4'b1000);
    do_rst;
    send(9'b000001011, 9);
    tick(1);
    chk("par_bad", {dn2, epar2, ep2}, 3'b110);
    // basic packet with clk_en every 4th cycle
    do_rst;
    vc = vcnt;
    for (int i = 6; i >= 0; i--) begin
      tick(7'b0100011 >> i);
      gap(3);
    end
    tick(1);
    chk("en4_d0", {v0, d0}, {4'b0100, 4'b0100});
    gap(1);
    chk("en4_d0_one_wide", {v0, rm0, b0, cl0}, {4'b0, 4'd2, 1'b1, 4'd3});
    gap(2);
    tick(0);
    chk("en4_d1", {v0, d0}, {4'b0100, 4'b0000});
    gap(3);
    tick(1);
    chk("en4_done", {dn0, v0, d0}, {1'b1, 4'b0100, 4'b0100});
    gap(1);
    chk("en4_after", {dn0, b0, v0}, 0);
    chk("en4_valid3", vcnt - vc, 3);
    // reset during 2nd data bit
    do_rst;
    dc = dcnt;
    send(8'b01000111, 8);
    @(negedge clk);
    rst = 1'b1;
    serin = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out", {v0, d0, b0, dn0, ep0, epar0, cp0, cl0, rm0}, 0);
    tick(1);
    tick(1);
    chk("midrst_nodone", dcnt - dc, 0);
    // back-to-back: port 1 len 1 data 1, then port 3 len 2 data 0,1
    dc = dcnt;
    send(8'b00100011, 8);
    chk("b2b_a", {dn0, v0, d0, cp0}, {1'b1, 4'b0010, 4'b0010, 2'd1});
    tick(0);
    chk("b2b_b_start", {b0, dn0}, 2'b10);
    send(8'b11001001, 8);
    chk("b2b_b", {dn0, v0, d0, cp0, cl0, ep0}, {1'b1, 4'b1000, 4'b1000, 2'd3, 4'd2, 1'b0});
    tick(1);
    chk("b2b_two_done", dcnt - dc, 2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
